mc_window_buffer: RTL

MC_WINDOW_BUFFER -- requirements
Module: mc_window_buffer

---
 rtl/window_buffer_pkg.sv | 20 ++
 rtl/chan_window_reg.sv | 36 +++
 rtl/mc_window_buffer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/window_buffer_pkg.sv
// Shared defaults and FSM state encoding for the multi-channel window buffer.
// Optional left/right zero padding is enabled by defining WINBUF_ZERO_PAD_EN.
package window_buffer_pkg;

  localparam int DEF_IO_DATA_WIDTH = 16;
  localparam int DEF_KERNEL_SIZE   = 3;
  localparam int DEF_NB_CHANNELS   = 4;

`ifdef WINBUF_ZERO_PAD_EN
  typedef enum logic [1:0] {ST_FILL, ST_STREAM, ST_HOLD, ST_FLUSH} win_state_e;
`else
  typedef enum logic [1:0] {ST_FILL, ST_STREAM, ST_HOLD} win_state_e;
`endif

  // Zero columns added on each side of a row when padding is enabled.
  function automatic int pad_cols(input int kernel_size);
    return (kernel_size - 1) / 2;
  endfunction

endpackage

// File: rtl/chan_window_reg.sv
// One channel's KxK window: shift left by one column on load, optional
// synchronous clear (clear together with load leaves only the new column).
module chan_window_reg
  import window_buffer_pkg::*;
#(
  parameter int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
  parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE
) (
  input  logic                                                    clk,
  input  logic                                                    srst_in,
  input  logic                                                    i_load,
  input  logic                                                    i_clr,
  input  logic [KERNEL_SIZE-1:0][IO_DATA_WIDTH-1:0]               i_col,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][IO_DATA_WIDTH-1:0] o_win
);

  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][IO_DATA_WIDTH-1:0] r_win;

  // NOTE: the window storage is reset explicitly because an empty window must
  // read as zeros (padding relies on it); plain data RAMs would not need this.
  always_ff @(posedge clk) begin
    if (srst_in) begin
      r_win <= '0;
    end else if (i_load || i_clr) begin
      for (int row = 0; row < KERNEL_SIZE; row++) begin
        for (int col = 0; col < KERNEL_SIZE - 1; col++) begin
          r_win[row][col] <= i_clr ? '0 : r_win[row][col+1];
        end
        r_win[row][KERNEL_SIZE-1] <= i_load ? i_col[row] : '0;
      end
    end
  end

  assign o_win = r_win;

endmodule

// File: rtl/mc_window_buffer.sv
// Channel-interleaved KxK sliding-window buffer with valid/ready on both sides.
// Define WINBUF_ZERO_PAD_EN for zero padding at row edges. Requires NB_CHANNELS >= 2.
module mc_window_buffer
  import window_buffer_pkg::*;
#(
  parameter int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
  parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
  parameter int NB_CHANNELS   = DEF_NB_CHANNELS
) (
  input  logic                                     clk,
  input  logic                                     srst_in,
  input  logic [KERNEL_SIZE-1:0][IO_DATA_WIDTH-1:0] in_col,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_last_col,
  output logic [NB_CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][IO_DATA_WIDTH-1:0] win_data,
  output logic                                     win_valid,
  input  logic                                     win_ready,
  output logic                                     win_last
);

  localparam int PTR_W = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;
  localparam int CNT_W = $clog2(KERNEL_SIZE + 1);
`ifdef WINBUF_ZERO_PAD_EN
  localparam int PAD = pad_cols(KERNEL_SIZE);
  localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(PAD);
`else
  localparam logic [CNT_W-1:0] CNT_BASE = '0;
`endif
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KERNEL_SIZE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NB_CHANNELS - 1);

  win_state_e       r_state, w_state_n;
  logic [PTR_W-1:0] r_ptr, w_ptr_n;
  logic [CNT_W-1:0] r_col_cnt, w_col_cnt_n;
  logic             r_win_valid, w_win_valid_n;
  logic             r_win_last, w_win_last_n;
  logic             w_accept, w_wrap, w_win_hs, w_clr, w_flush_shift;
  logic [KERNEL_SIZE-1:0][IO_DATA_WIDTH-1:0] w_col_in;

`ifdef WINBUF_ZERO_PAD_EN
  // r_in_flush spans from the last real window to the final padded one.
  logic             r_in_flush, w_in_flush_n;
  logic [CNT_W-1:0] r_flush_cnt, w_flush_cnt_n;
  assign in_ready = !r_in_flush && (!r_win_valid || win_ready);
`else
  assign in_ready = !r_win_valid || win_ready;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_wrap   = w_accept && (r_ptr == PTR_LAST);
  assign w_win_hs = r_win_valid && win_ready;

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_n     = r_state;
    w_ptr_n       = r_ptr;
    w_col_cnt_n   = r_col_cnt;
    w_win_valid_n = r_win_valid;
    w_win_last_n  = r_win_last;
    w_clr         = 1'b0;
    w_flush_shift = 1'b0;
`ifdef WINBUF_ZERO_PAD_EN
    w_in_flush_n  = r_in_flush;
    w_flush_cnt_n = r_flush_cnt;
`endif
    if (w_accept) begin
      w_ptr_n = w_wrap ? '0 : r_ptr + PTR_W'(1);
    end
    case (r_state)
      ST_FILL, ST_STREAM: begin
        if (w_wrap) begin
          w_col_cnt_n = (r_col_cnt == CNT_FULL) ? CNT_FULL : r_col_cnt + CNT_W'(1);
          if (w_col_cnt_n == CNT_FULL) begin
            w_state_n     = ST_HOLD;
            w_win_valid_n = 1'b1;
`ifdef WINBUF_ZERO_PAD_EN
            w_win_last_n  = 1'b0;
            w_in_flush_n  = in_last_col;
            w_flush_cnt_n = CNT_W'(PAD);
`else
            w_win_last_n  = in_last_col;
`endif
          end
        end
      end
      ST_HOLD: begin
        if (w_win_hs) begin
          w_win_valid_n = 1'b0;
          w_win_last_n  = 1'b0;
          if (r_win_last) begin
            w_clr       = 1'b1;
            w_col_cnt_n = CNT_BASE;
            w_state_n   = ST_FILL;
`ifdef WINBUF_ZERO_PAD_EN
            w_in_flush_n = 1'b0;
          end else if (r_in_flush) begin
            w_state_n = ST_FLUSH;
`endif
          end else begin
            w_state_n = ST_STREAM;
          end
        end
      end
`ifdef WINBUF_ZERO_PAD_EN
      ST_FLUSH: begin
        w_flush_shift = 1'b1;
        w_flush_cnt_n = r_flush_cnt - CNT_W'(1);
        w_state_n     = ST_HOLD;
        w_win_valid_n = 1'b1;
        w_win_last_n  = (r_flush_cnt == CNT_W'(1));
      end
`endif
      default: w_state_n = ST_FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (srst_in) begin
      r_state     <= ST_FILL;
      r_ptr       <= '0;
      r_col_cnt   <= CNT_BASE;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
`ifdef WINBUF_ZERO_PAD_EN
      r_in_flush  <= 1'b0;
      r_flush_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_ptr       <= w_ptr_n;
      r_col_cnt   <= w_col_cnt_n;
      r_win_valid <= w_win_valid_n;
      r_win_last  <= w_win_last_n;
`ifdef WINBUF_ZERO_PAD_EN
      r_in_flush  <= w_in_flush_n;
      r_flush_cnt <= w_flush_cnt_n;
`endif
    end
  end

  assign w_col_in  = w_flush_shift ? '0 : in_col;
  assign win_valid = r_win_valid;
  assign win_last  = r_win_last;

  for (genvar g = 0; g < NB_CHANNELS; g++) begin : g_chan
    logic w_load;
    assign w_load = (w_accept && (r_ptr == PTR_W'(g))) || w_flush_shift;

    chan_window_reg #(
      .IO_DATA_WIDTH (IO_DATA_WIDTH),
      .KERNEL_SIZE   (KERNEL_SIZE)
    ) u_chan (
      .clk     (clk),
      .srst_in (srst_in),
      .i_load  (w_load),
      .i_clr   (w_clr),
      .i_col   (w_col_in),
      .o_win   (win_data[g])
    );
  end

endmodule
